// File: rtl/mac_pkg.sv
// Shared definitions for the dual-dataflow MAC tile: instruction bit
// positions and dataflow mode encodings.
package mac_pkg;

    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_DRAIN = 2;

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } mode_e;

endpackage

// File: rtl/mac_tile_dual_mac.sv
// Combinational multiply-add: out = c + a * b, wrapping modulo 2^psum_bw.
// a is signed or unsigned depending on act_signed; b is always signed.
module mac #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int act_signed = 0
) (
    input  logic [bw-1:0]      a,
    input  logic [bw-1:0]      b,
    input  logic [psum_bw-1:0] c,
    output logic [psum_bw-1:0] out
);

    logic signed [psum_bw-1:0] a_ext;
    logic signed [psum_bw-1:0] b_ext;

    // Extend both operands to the full psum width so the product wraps there
    always_comb begin
        a_ext = (act_signed != 0) ? {{(psum_bw-bw){a[bw-1]}}, a}
                                  : {{(psum_bw-bw){1'b0}}, a};
        b_ext = {{(psum_bw-bw){b[bw-1]}}, b};
        out   = c + (a_ext * b_ext);
    end

endmodule

// File: rtl/mac_tile_dual.sv
// Systolic MAC tile with weight-stationary and output-stationary dataflows.
// Activations/instructions flow west->east, psums/weights/results flow
// north->south. OS mode keeps a local accumulator drained down the column.
module mac_tile_dual
    import mac_pkg::*;
#(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int act_signed = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s
);

    mode_e              mode_q;
    logic [bw-1:0]      b_q;
    logic [psum_bw-1:0] acc_q;
    logic               load_ready_q;
    logic               drain_done_q;

    logic [bw-1:0]      mul_b;
    logic [psum_bw-1:0] add_c;
    logic [psum_bw-1:0] mac_out;

    // WS multiplies by the stored weight and adds the incoming psum;
    // OS multiplies by the weight arriving from the north and adds acc_q
    always_comb begin
        mul_b = (mode_q == MODE_OS) ? in_n[bw-1:0] : b_q;
        add_c = (mode_q == MODE_OS) ? acc_q : in_n;
    end

    mac #(
        .bw        (bw),
        .psum_bw   (psum_bw),
        .act_signed(act_signed)
    ) u_mac (
        .a  (in_w),
        .b  (mul_b),
        .c  (add_c),
        .out(mac_out)
    );

    // Tile state: mode switch takes priority and swallows that edge's instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= MODE_WS;
            b_q          <= '0;
            acc_q        <= '0;
            load_ready_q <= 1'b1;
            drain_done_q <= 1'b0;
            out_e        <= '0;
            inst_e       <= '0;
            out_s        <= '0;
        end else if (mode_e'(mode) != mode_q) begin
            mode_q       <= mode_e'(mode);
            acc_q        <= '0;
            load_ready_q <= 1'b1;
            drain_done_q <= 1'b0;
            inst_e       <= '0;
            out_s        <= '0;
        end else if (mode_q == MODE_WS) begin
            if (inst_w[INST_LOAD] || inst_w[INST_EXEC])
                out_e <= in_w;
            // The first load seen latches this tile's weight; later loads are
            // passed east so each column tile captures the next weight in line
            if (inst_w[INST_LOAD] && load_ready_q) begin
                b_q          <= in_w;
                load_ready_q <= 1'b0;
            end
            inst_e[INST_LOAD]  <= inst_w[INST_LOAD] & ~load_ready_q;
            inst_e[INST_EXEC]  <= inst_w[INST_EXEC];
            inst_e[INST_DRAIN] <= 1'b0;
            out_s <= inst_w[INST_EXEC] ? mac_out : in_n;
        end else begin
            if (inst_w[INST_EXEC])
                out_e <= in_w;
            inst_e <= inst_w;
            if (inst_w[INST_DRAIN]) begin
                // First drain cycle emits our own result, then we relay the
                // results of the tiles above for the rest of the drain
                if (!drain_done_q) begin
                    out_s        <= acc_q;
                    acc_q        <= '0;
                    drain_done_q <= 1'b1;
                end else begin
                    out_s <= in_n;
                end
            end else begin
                drain_done_q <= 1'b0;
                if (inst_w[INST_EXEC]) begin
                    acc_q <= mac_out;
                    out_s <= {{(psum_bw-bw){1'b0}}, in_n[bw-1:0]};
                end else begin
                    out_s <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_tile_dual.sv
// Self-checking bench for mac_tile_dual: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mac_tile_dual;

    localparam int BW  = 4;
    localparam int PBW = 16;
    localparam int ACT_S = 0;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           mode = 1'b0;
    logic [BW-1:0]  in_w = '0;
    logic [BW-1:0]  out_e;
    logic [2:0]     inst_w = '0;
    logic [2:0]     inst_e;
    logic [PBW-1:0] in_n = '0;
    logic [PBW-1:0] out_s;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [BW-1:0]  m_b;
    logic [PBW-1:0] m_acc;
    logic [PBW-1:0] m_out_s;
    logic [BW-1:0]  m_out_e;
    logic [2:0]     m_inst_e;
    logic           m_ready, m_dd, m_mode;

    mac_tile_dual #(.bw(BW), .psum_bw(PBW), .act_signed(ACT_S)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_w(in_w), .out_e(out_e), .inst_w(inst_w), .inst_e(inst_e),
        .in_n(in_n), .out_s(out_s)
    );

    always #5 clk = ~clk;

    function automatic int act_val(logic [BW-1:0] a);
        return (ACT_S != 0) ? int'($signed(a)) : int'(a);
    endfunction

    function automatic int wval(logic [BW-1:0] w);
        return int'($signed(w));
    endfunction

    task automatic model_reset();
        m_b = '0; m_acc = '0; m_out_s = '0; m_out_e = '0; m_inst_e = '0;
        m_ready = 1'b1; m_dd = 1'b0; m_mode = 1'b0;
    endtask

    task automatic model_edge();
        if (mode != m_mode) begin
            m_mode = mode; m_acc = '0; m_ready = 1'b1; m_dd = 1'b0;
            m_inst_e = '0; m_out_s = '0;
            return;
        end
        if (!m_mode) begin
            if (inst_w[0] || inst_w[1]) m_out_e = in_w;
            m_inst_e = {1'b0, inst_w[1], inst_w[0] && !m_ready};
            if (inst_w[1]) m_out_s = 16'(int'(in_n) + act_val(in_w) * wval(m_b));
            else           m_out_s = in_n;
            if (inst_w[0] && m_ready) begin m_b = in_w; m_ready = 1'b0; end
        end else begin
            if (inst_w[1]) m_out_e = in_w;
            m_inst_e = inst_w;
            if (inst_w[2]) begin
                if (!m_dd) begin m_out_s = m_acc; m_acc = '0; m_dd = 1'b1; end
                else m_out_s = in_n;
            end else begin
                m_dd = 1'b0;
                if (inst_w[1]) begin
                    m_acc = 16'(int'(m_acc) + act_val(in_w) * wval(in_n[BW-1:0]));
                    m_out_s = {12'b0, in_n[BW-1:0]};
                end else m_out_s = '0;
            end
        end
    endtask

    // one clock: model follows the same edge, then settle past it
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
    endtask

    task automatic drive(logic m, logic [2:0] i, logic [BW-1:0] a, logic [PBW-1:0] n);
        mode = m; inst_w = i; in_w = a; in_n = n;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 3'b000, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    task automatic enter_os();
        do_reset();
        drive(1, 3'b000, 0, 0);
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 3'b000, 4'hA, 16'h1234);
        #3;
        checks++;
        if (out_e !== 4'h0 || inst_e !== 3'b000 || out_s !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: out_e=%h inst_e=%b out_s=%h required 0/000/0000", out_e, inst_e, out_s);
        end
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_load();
        do_reset();
        drive(0, 3'b001, 4'd5, 0);
        cycle();
        checks++;
        if (inst_e !== 3'b000 || out_e !== 4'd5) begin
            failures++;
            $display("FAIL load_first: inst_e=%b out_e=%0d required 000/5", inst_e, out_e);
        end
        drive(0, 3'b001, 4'd3, 0);
        cycle();
        checks++;
        if (inst_e !== 3'b001 || out_e !== 4'd3) begin
            failures++;
            $display("FAIL load_second: inst_e=%b out_e=%0d required 001/3", inst_e, out_e);
        end
        drive(0, 3'b010, 4'd2, 16'd10);
        cycle();
        checks++;
        if (out_s !== 16'd20 || inst_e !== 3'b010) begin
            failures++;
            $display("FAIL load_weight: out_s=%0d inst_e=%b required 20/010", out_s, inst_e);
        end
        drive(0, 3'b000, 4'd9, 16'd77);
        cycle();
        checks++;
        if (out_s !== 16'd77 || out_e !== 4'd2) begin
            failures++;
            $display("FAIL ws_bypass: out_s=%0d out_e=%0d required 77/2", out_s, out_e);
        end
    endtask

    task automatic test_ws_exec();
        do_reset();
        drive(0, 3'b001, 4'hE, 0);
        cycle();
        drive(0, 3'b010, 4'd7, 16'd100);
        cycle();
        checks++;
        if (out_s !== 16'd86) begin
            failures++;
            $display("FAIL ws_signed_exec: out_s=%0d required 86", out_s);
        end
    endtask

    task automatic test_ws_wrap();
        do_reset();
        drive(0, 3'b001, 4'd1, 0);
        cycle();
        drive(0, 3'b010, 4'd1, 16'hFFFF);
        cycle();
        checks++;
        if (out_s !== 16'h0000) begin
            failures++;
            $display("FAIL ws_wrap: out_s=%h required 0000", out_s);
        end
    endtask

    task automatic test_os_drain();
        logic [PBW-1:0] relay [3];
        relay[0] = 16'h0000; relay[1] = 16'h0ABC; relay[2] = 16'h1234;
        enter_os();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 3'b010, 4'd2, 16'(k));
            cycle();
            checks++;
            if (out_s !== 16'(k) || out_e !== 4'd2) begin
                failures++;
                $display("FAIL os_weight_fwd[%0d]: out_s=%0d out_e=%0d required %0d/2", k, out_s, out_e, k);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 3'b100, 4'd0, relay[k]);
            cycle();
            checks++;
            if (out_s !== ((k == 0) ? 16'd20 : relay[k]) || inst_e !== 3'b100) begin
                failures++;
                $display("FAIL os_drain[%0d]: out_s=%h inst_e=%b required %h/100", k, out_s, inst_e,
                         (k == 0) ? 16'd20 : relay[k]);
            end
        end
        drive(1, 3'b000, 4'd0, 16'h5555);
        cycle();
        checks++;
        if (out_s !== 16'h0) begin
            failures++;
            $display("FAIL os_idle: out_s=%h required 0000", out_s);
        end
        drive(1, 3'b100, 4'd0, 16'h5555);
        cycle();
        checks++;
        if (out_s !== 16'h0) begin
            failures++;
            $display("FAIL os_acc_cleared: out_s=%h required 0000", out_s);
        end
    endtask

    task automatic test_drain_priority();
        enter_os();
        drive(1, 3'b010, 4'd3, 16'd3);
        cycle();
        drive(1, 3'b110, 4'd5, 16'd4);
        cycle();
        checks++;
        if (out_s !== 16'd9 || inst_e !== 3'b110 || out_e !== 4'd5) begin
            failures++;
            $display("FAIL drain_priority: out_s=%0d inst_e=%b out_e=%0d required 9/110/5", out_s, inst_e, out_e);
        end
        drive(1, 3'b000, 4'd0, 0);
        cycle();
        drive(1, 3'b100, 4'd0, 0);
        cycle();
        checks++;
        if (out_s !== 16'd0) begin
            failures++;
            $display("FAIL drain_no_accum: out_s=%0d required 0", out_s);
        end
    endtask

    task automatic test_mode_change();
        enter_os();
        drive(1, 3'b010, 4'd3, 16'd4);
        cycle();
        drive(0, 3'b010, 4'd5, 16'd7);
        cycle();
        checks++;
        if (out_s !== 16'd0 || inst_e !== 3'b000) begin
            failures++;
            $display("FAIL mode_change_outputs: out_s=%0d inst_e=%b required 0/000", out_s, inst_e);
        end
        drive(0, 3'b001, 4'd3, 0);
        cycle();
        checks++;
        if (inst_e !== 3'b000) begin
            failures++;
            $display("FAIL mode_change_load_ready: inst_e=%b required 000", inst_e);
        end
        drive(0, 3'b010, 4'd2, 16'd1);
        cycle();
        checks++;
        if (out_s !== 16'd7) begin
            failures++;
            $display("FAIL mode_change_reload: out_s=%0d required 7", out_s);
        end
        drive(1, 3'b000, 0, 0);
        cycle();
        drive(1, 3'b100, 0, 0);
        cycle();
        checks++;
        if (out_s !== 16'd0) begin
            failures++;
            $display("FAIL mode_change_acc_clear: out_s=%0d required 0", out_s);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 3'b001, 4'd1, 0);
        cycle();
        drive(0, 3'b010, 4'd5, 16'd3);
        cycle();
        checks++;
        if (out_s !== 16'd8) begin
            failures++;
            $display("FAIL async_pre: out_s=%0d required 8", out_s);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_s !== 16'd0 || out_e !== 4'd0 || inst_e !== 3'b000) begin
            failures++;
            $display("FAIL async_reset: out_s=%0d out_e=%0d inst_e=%b required 0/0/000", out_s, out_e, inst_e);
        end
        model_reset();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic m;
        do_reset();
        m = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) m = ~m;
            drive(m, 3'($urandom_range(0, 7)), 4'($urandom), 16'($urandom));
            cycle();
            checks++;
            if (out_s !== m_out_s || out_e !== m_out_e || inst_e !== m_inst_e) begin
                failures++;
                $display("FAIL random[%0d]: out_s=%h out_e=%h inst_e=%b required %h/%h/%b",
                         n, out_s, out_e, inst_e, m_out_s, m_out_e, m_inst_e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_ws_exec();
        test_ws_wrap();
        test_os_drain();
        test_drain_priority();
        test_mode_change();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
